// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state encoding and default bus widths for apb_master.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
endpackage

// File: rtl/apb_master_timer.sv
// apb_master_timer: counts stalled ACCESS cycles and flags the one that reaches TIMEOUT_CYCLES.
module apb_master_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cnt <= '0;
        else if (i_clear) cnt <= '0;
        else if (i_inc) cnt <= cnt + 1'b1;
    // The stalled cycle that would bring the count to TIMEOUT_CYCLES ends the access.
    assign o_timeout = i_inc && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding command-to-APB bridge (IDLE/SETUP/ACCESS/RESP).
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES stalled cycles.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic              i_cmd_write,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_paddr,
    output logic              o_psel,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic [DATA_W-1:0] i_prdata,
    input  logic              i_pready,
    input  logic              i_pslverr
);
    apb_state_e state, state_nx;
    logic live, timeout, done;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (state == SETUP),
        .i_inc    (state == ACCESS && !i_pready),
        .o_timeout(timeout)
    );
`else
    // No wait limit in this build; TIMEOUT_CYCLES is inert.
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    assign done = state == ACCESS && (i_pready || timeout);

    // live holds off o_cmd_ready until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
        end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (o_cmd_ready && i_cmd_valid) ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = done ? RESP : ACCESS;
            RESP:    state_nx = i_rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = live && state == IDLE;
        o_psel      = state == SETUP || state == ACCESS;
        o_penable   = state == ACCESS;
        o_rsp_valid = state == RESP;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_paddr  <= '0;
            o_pwrite <= 1'b0;
            o_pwdata <= '0;
        end else if (o_cmd_ready && i_cmd_valid) begin
            o_paddr  <= i_cmd_addr;
            o_pwrite <= i_cmd_write;
            o_pwdata <= i_cmd_wdata;
        end

    // A timeout completes with error and zero data regardless of the slave.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else if (done) begin
            o_rsp_rdata <= (i_pready && !o_pwrite) ? i_prdata : '0;
            o_rsp_err   <= i_pready ? i_pslverr : 1'b1;
        end
endmodule
